// File: rtl/ball_motion.sv
// Breakout-style ball motion engine on a 16x16 grid.
// The ball waits on the paddle (IDLE), flies on game ticks (MOVE), pauses one
// tick after falling past the paddle (LOST) and freezes once all balls are
// spent (OVER). Wall, ceiling, brick and paddle reflections are resolved on the
// same tick the ball moves, so a flipped ball steps away from the obstacle.
module ball_motion #(
  parameter int LIVES_INIT = 3,
  parameter int PADDLE_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        launch,
  input  logic [3:0]  paddle_col,
  input  logic [55:0] bricks,
  output logic [3:0]  ball_row,
  output logic [3:0]  ball_col,
  output logic [1:0]  ball_dir,
  output logic        brick_hit,
  output logic [2:0]  lives,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_LOST,
    S_OVER
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [1:0]  dir_q, dir_d;
  logic        hit_q, hit_d;
  logic [2:0]  lives_q, lives_d;
  logic        over_q, over_d;

  // Resting position above the paddle; clamp at the right edge.
  logic [3:0]  home_col;

  // One-step motion candidates, computed from the current ball state.
  logic        wall_flip;
  logic        dir_h;
  logic [3:0]  next_col;
  logic        row_has_bricks;
  logic [2:0]  brick_row;
  logic [5:0]  brick_idx;
  logic        brick_here;
  logic [4:0]  paddle_end;
  logic        on_paddle;
  logic        flip_v;
  logic        brick_flip;
  logic        falls_out;
  logic        dir_v;
  logic [3:0]  next_row;

  // Geometry of a single game step: horizontal reflection first, then the
  // vertical decision using the already-reflected column.
  always_comb begin
    home_col  = (paddle_col == 4'd15) ? 4'd15 : paddle_col + 4'd1;

    wall_flip = ((col_q == 4'd0) && !dir_q[0]) || ((col_q == 4'd15) && dir_q[0]);
    dir_h     = dir_q[0] ^ wall_flip;
    next_col  = dir_h ? col_q + 4'd1 : col_q - 4'd1;

    // Brick rows 1..7 are reached from ball rows 2..8 moving up.
    row_has_bricks = (row_q >= 4'd2) && (row_q <= 4'd8);
    brick_row      = 3'(row_q - 4'd2);
    brick_idx      = {brick_row, next_col[3:1]};
    brick_here     = row_has_bricks && bricks[brick_idx];

    paddle_end = {1'b0, paddle_col} + 5'(PADDLE_W - 1);
    on_paddle  = ({1'b0, next_col} >= {1'b0, paddle_col}) &&
                 ({1'b0, next_col} <= paddle_end);

    flip_v     = 1'b0;
    brick_flip = 1'b0;
    falls_out  = 1'b0;
    if (!dir_q[1]) begin
      if (row_q == 4'd0) begin
        flip_v = 1'b1;
      end else if (brick_here) begin
        flip_v     = 1'b1;
        brick_flip = 1'b1;
      end
    end else if (row_q == 4'd14) begin
      if (on_paddle) begin
        flip_v = 1'b1;
      end else begin
        falls_out = 1'b1;
      end
    end

    dir_v    = dir_q[1] ^ flip_v;
    next_row = dir_v ? row_q + 4'd1 : row_q - 4'd1;
  end

  // Next-state and output register values for the game FSM.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    lives_d = lives_q;

    case (state_q)
      S_IDLE: begin
        row_d = 4'd14;
        col_d = home_col;
        dir_d = 2'b01;
        if (launch) begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (tick) begin
          row_d = next_row;
          col_d = next_col;
          dir_d = {dir_v, dir_h};
          hit_d = brick_flip;
          if (falls_out) begin
            state_d = S_LOST;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end
        end
      end
      S_LOST: begin
        if (tick) begin
          if (lives_q != 3'd0) begin
            state_d = S_IDLE;
            row_d   = 4'd14;
            col_d   = home_col;
            dir_d   = 2'b01;
          end else begin
            state_d = S_OVER;
          end
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    over_d = (state_d == S_OVER);
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 4'd14;
      col_q   <= home_col;
      dir_q   <= 2'b01;
      hit_q   <= 1'b0;
      lives_q <= 3'(LIVES_INIT);
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
      lives_q <= lives_d;
      over_q  <= over_d;
    end
  end

  assign ball_row  = row_q;
  assign ball_col  = col_q;
  assign ball_dir  = dir_q;
  assign brick_hit = hit_q;
  assign lives     = lives_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: scripted flights with hand-traced positions.
module tb_ball_motion;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        launch;
  logic [3:0]  paddle_col;
  logic [55:0] bricks;
  logic [3:0]  ball_row;
  logic [3:0]  ball_col;
  logic [1:0]  ball_dir;
  logic        brick_hit;
  logic [2:0]  lives;
  logic        game_over;

  int n_checks = 0;
  int n_pass   = 0;

  ball_motion #(.LIVES_INIT(3), .PADDLE_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .launch     (launch),
    .paddle_col (paddle_col),
    .bricks     (bricks),
    .ball_row   (ball_row),
    .ball_col   (ball_col),
    .ball_dir   (ball_dir),
    .brick_hit  (brick_hit),
    .lives      (lives),
    .game_over  (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got=%0h", tag, got);
    end else begin
      $display("FAIL %-16s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [3:0] r, input logic [3:0] c,
                           input logic [1:0] d);
    check(tag, {22'd0, ball_row, ball_col, ball_dir}, {22'd0, r, c, d});
  endtask

  // One clock with the given tick/launch levels, sampled 1 time unit after the edge.
  task automatic cyc(input logic t, input logic l);
    tick   = t;
    launch = l;
    @(posedge clock);
    #1;
    tick   = 1'b0;
    launch = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; launch = 1'b0;
    paddle_col = 4'd5; bricks = '0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset = 1'b0;

    // Reset state
    check_pos("rst_pos", 4'd14, 4'd6, 2'b01);
    check("rst_lives", {29'd0, lives}, 32'd3);
    check("rst_over", {31'd0, game_over}, 32'd0);
    check("rst_hit", {31'd0, brick_hit}, 32'd0);

    // First flight, paddle at 5, no bricks
    cyc(1'b0, 1'b1);
    check_pos("launch_pos", 4'd14, 4'd6, 2'b01);
    ticks(1);  check_pos("t1", 4'd13, 4'd7, 2'b01);
    ticks(8);  check_pos("t9_rwall", 4'd5, 4'd15, 2'b01);
    ticks(1);  check_pos("t10_flip", 4'd4, 4'd14, 2'b00);
    ticks(4);  check_pos("t14_top", 4'd0, 4'd10, 2'b00);
    ticks(1);  check_pos("t15_down", 4'd1, 4'd9, 2'b10);
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    check_pos("hold", 4'd1, 4'd9, 2'b10);
    ticks(9);  check_pos("t24_lwall", 4'd10, 4'd0, 2'b10);
    ticks(1);  check_pos("t25_flip", 4'd11, 4'd1, 2'b11);
    ticks(3);  check_pos("t28_row14", 4'd14, 4'd4, 2'b11);
    ticks(1);  check_pos("t29_paddle", 4'd13, 4'd5, 2'b01);
    ticks(28); check_pos("t57_lost", 4'd15, 4'd3, 2'b11);
    check("lost_lives", {29'd0, lives}, 32'd2);
    check("lost_over", {31'd0, game_over}, 32'd0);
    cyc(1'b0, 1'b0);
    check_pos("lost_hold", 4'd15, 4'd3, 2'b11);
    ticks(1);  check_pos("back_idle", 4'd14, 4'd6, 2'b01);
    ticks(2);  check_pos("idle_tick", 4'd14, 4'd6, 2'b01);

    // Second flight, paddle at 0: top-right corner, paddle bounce, bricks
    paddle_col = 4'd0;
    cyc(1'b0, 1'b0); check_pos("idle_track", 4'd14, 4'd1, 2'b01);
    cyc(1'b0, 1'b1);
    ticks(14); check_pos("corner_in", 4'd0, 4'd15, 2'b01);
    ticks(1);  check_pos("corner_out", 4'd1, 4'd14, 2'b10);
    ticks(13); check_pos("b_row14", 4'd14, 4'd1, 2'b10);
    ticks(1);  check_pos("b_paddle", 4'd13, 4'd0, 2'b00);
    ticks(1);  check_pos("b_lwall", 4'd12, 4'd1, 2'b01);
    ticks(3);  check_pos("b_94", 4'd9, 4'd4, 2'b01);
    bricks = 56'd1 << 50;
    ticks(1);  check_pos("b_85", 4'd8, 4'd5, 2'b01);
    check("nohit_row8", {31'd0, brick_hit}, 32'd0);
    ticks(1);  check_pos("b_76_miss", 4'd7, 4'd6, 2'b01);
    check("nohit_col", {31'd0, brick_hit}, 32'd0);
    bricks = (56'd1 << 50) | (56'd1 << 43);
    ticks(1);  check_pos("brick_bounce", 4'd8, 4'd7, 2'b11);
    check("brick_hit", {31'd0, brick_hit}, 32'd1);
    cyc(1'b0, 1'b0);
    check("hit_pulse_end", {31'd0, brick_hit}, 32'd0);
    bricks = '0;
    ticks(6);  check_pos("b_row14_r", 4'd14, 4'd13, 2'b11);
    ticks(1);  check_pos("b_lost", 4'd15, 4'd14, 2'b11);
    check("lives_1", {29'd0, lives}, 32'd1);
    ticks(1);  check_pos("b_idle", 4'd14, 4'd1, 2'b01);

    // Third flight: last ball lost, game over
    cyc(1'b0, 1'b1);
    ticks(28); check_pos("c_row14", 4'd14, 4'd1, 2'b10);
    paddle_col = 4'd8;
    ticks(1);  check_pos("c_lost", 4'd15, 4'd0, 2'b10);
    check("lives_0", {29'd0, lives}, 32'd0);
    check("lost0_over", {31'd0, game_over}, 32'd0);
    ticks(1);
    check("over", {31'd0, game_over}, 32'd1);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
    check_pos("over_frozen", 4'd15, 4'd0, 2'b10);
    check("over_hold", {31'd0, game_over}, 32'd1);
    check("over_lives", {29'd0, lives}, 32'd0);

    reset = 1'b1; cyc(1'b1, 1'b1); reset = 1'b0;
    check_pos("rst2_pos", 4'd14, 4'd9, 2'b01);
    check("rst2_lives", {29'd0, lives}, 32'd3);
    check("rst2_over", {31'd0, game_over}, 32'd0);

    // Reset mid-flight with a simultaneous tick
    paddle_col = 4'd5;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    ticks(3);  check_pos("d_flight", 4'd11, 4'd9, 2'b01);
    reset = 1'b1; cyc(1'b1, 1'b0); reset = 1'b0;
    check_pos("d_rst", 4'd14, 4'd6, 2'b01);
    check("d_rst_hit", {31'd0, brick_hit}, 32'd0);
    ticks(2);  check_pos("d_idle", 4'd14, 4'd6, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
